// File: rtl/cache_controller.sv
// Direct-mapped, write-through / no-write-allocate cache controller, 4 words per line.
// Optional statistics counters are enabled by defining CACHE_STATS_EN.
module cache_controller #(
    parameter int INDEX_W = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cpu_rd,
    input  logic               cpu_wr,
    input  logic [9:0]         cpu_addr,
    input  logic [31:0]        cpu_wdata,
    output logic               cpu_ack,
    output logic               cpu_stall,
    output logic               cache_we,
    output logic [INDEX_W-1:0] cache_index,
    output logic [1:0]         cache_word,
    output logic [31:0]        cache_wdata,
    output logic [9:0]         mem_word_address,
    output logic [31:0]        mem_data_in,
    output logic               write_in_mem,
    output logic               move_to_cache,
    input  logic [31:0]        mem_data
`ifdef CACHE_STATS_EN
    ,
    output logic [15:0]        hit_count,
    output logic [15:0]        miss_count
`endif
);

    // state  | meaning
    // IDLE   | waiting for a request; read hits acknowledged combinationally
    // REFILL | streaming a line from memory, cnt = beat number 0..3
    // LAST   | writing the final word, marking the line valid
    // WRITE  | single-cycle write-through to memory (and cache on hit)

    localparam int TAG_W = 8 - INDEX_W;
    localparam int LINES = 2 ** INDEX_W;

    typedef enum logic [1:0] {IDLE, REFILL, LAST, WRITE} state_t;

    state_t             state;
    state_t             state_nxt;
    logic [1:0]         cnt;
    logic [LINES-1:0]   valid;
    logic [TAG_W-1:0]   tags [LINES];
    logic [TAG_W-1:0]   req_tag;
    logic [INDEX_W-1:0] req_index;

    logic [TAG_W-1:0]   addr_tag;
    logic [INDEX_W-1:0] addr_index;
    logic [1:0]         addr_word;
    logic               hit;

    assign addr_tag   = cpu_addr[9:2+INDEX_W];
    assign addr_index = cpu_addr[1+INDEX_W:2];
    assign addr_word  = cpu_addr[1:0];
    assign hit        = valid[addr_index] && (tags[addr_index] == addr_tag);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt       <= 2'd0;
            valid     <= '0;
            req_tag   <= '0;
            req_index <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (!cpu_wr && cpu_rd && !hit) begin
                        cnt       <= 2'd0;
                        req_tag   <= addr_tag;
                        req_index <= addr_index;
                    end
                end
                REFILL:  cnt <= cnt + 2'd1;
                LAST:    valid[req_index] <= 1'b1;
                default: ;
            endcase
        end
    end

    // Tags need no reset: a line is only trusted once its valid bit is set.
    always_ff @(posedge clk) begin
        if (state == LAST) begin
            tags[req_index] <= req_tag;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (cpu_wr) begin
                    state_nxt = WRITE;
                end else if (cpu_rd && !hit) begin
                    state_nxt = REFILL;
                end
            end
            REFILL: begin
                if (cnt == 2'd3) begin
                    state_nxt = LAST;
                end
            end
            LAST:    state_nxt = IDLE;
            WRITE:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs are forced low while rst is high, even with a request still held.
    always_comb begin
        cpu_ack          = 1'b0;
        cpu_stall        = 1'b0;
        cache_we         = 1'b0;
        cache_index      = '0;
        cache_word       = 2'd0;
        cache_wdata      = 32'd0;
        mem_word_address = 10'd0;
        mem_data_in      = 32'd0;
        write_in_mem     = 1'b0;
        move_to_cache    = 1'b0;
        if (!rst) begin
            case (state)
                IDLE: begin
                    if (cpu_wr) begin
                        cpu_stall = 1'b1;
                    end else if (cpu_rd) begin
                        cpu_ack   = hit;
                        cpu_stall = !hit;
                    end
                end
                REFILL: begin
                    cpu_stall        = 1'b1;
                    move_to_cache    = 1'b1;
                    mem_word_address = {req_tag, req_index, 2'b00};
                    if (cnt != 2'd0) begin
                        cache_we    = 1'b1;
                        cache_index = req_index;
                        cache_word  = 2'(cnt - 2'd1);
                        cache_wdata = mem_data;
                    end
                end
                LAST: begin
                    cpu_stall   = 1'b1;
                    cache_we    = 1'b1;
                    cache_index = req_index;
                    cache_word  = 2'd3;
                    cache_wdata = mem_data;
                end
                WRITE: begin
                    cpu_stall        = 1'b1;
                    cpu_ack          = 1'b1;
                    write_in_mem     = 1'b1;
                    mem_word_address = cpu_addr;
                    mem_data_in      = cpu_wdata;
                    if (hit) begin
                        cache_we    = 1'b1;
                        cache_index = addr_index;
                        cache_word  = addr_word;
                        cache_wdata = cpu_wdata;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef CACHE_STATS_EN
    logic after_refill;
    logic idle_rd;

    assign idle_rd = (state == IDLE) && cpu_rd && !cpu_wr;

    // The ack that completes a refill is a hit in IDLE but belongs to the miss.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            after_refill <= 1'b0;
            hit_count    <= 16'd0;
            miss_count   <= 16'd0;
        end else begin
            after_refill <= (state == LAST);
            if (idle_rd && hit && !after_refill && hit_count != 16'hFFFF) begin
                hit_count <= hit_count + 16'd1;
            end
            if (idle_rd && !hit && miss_count != 16'hFFFF) begin
                miss_count <= miss_count + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_cache_controller.sv
// Randomized scoreboard bench for cache_controller: a word-level cache/memory model
// predicts hit/miss, latency, memory traffic and read data for each CPU request.
module tb_cache_controller;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_rd, cpu_wr;
    logic [9:0]  cpu_addr;
    logic [31:0] cpu_wdata;
    logic        cpu_ack, cpu_stall;
    logic        cache_we;
    logic [4:0]  cache_index;
    logic [1:0]  cache_word;
    logic [31:0] cache_wdata;
    logic [9:0]  mem_word_address;
    logic [31:0] mem_data_in;
    logic        write_in_mem, move_to_cache;
    logic [31:0] mem_data = 32'd0;
`ifdef CACHE_STATS_EN
    logic [15:0] hit_count, miss_count;
`endif

    cache_controller #(.INDEX_W(5)) dut (
        .clk(clk), .rst(rst),
        .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ack(cpu_ack), .cpu_stall(cpu_stall),
        .cache_we(cache_we), .cache_index(cache_index), .cache_word(cache_word),
        .cache_wdata(cache_wdata),
        .mem_word_address(mem_word_address), .mem_data_in(mem_data_in),
        .write_in_mem(write_in_mem), .move_to_cache(move_to_cache),
        .mem_data(mem_data)
`ifdef CACHE_STATS_EN
        , .hit_count(hit_count), .miss_count(miss_count)
`endif
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Environment: data memory and the external cache data array
    logic [31:0] env_mem [1024];
    logic [31:0] cache_arr [128];
    logic [1:0]  beat = 2'd0;

    always @(posedge clk) begin
        if (move_to_cache) begin
            mem_data <= env_mem[mem_word_address + 10'(beat)];
            beat     <= beat + 2'd1;
        end else begin
            beat <= 2'd0;
        end
        if (write_in_mem) env_mem[mem_word_address] <= mem_data_in;
        if (cache_we) cache_arr[{cache_index, cache_word}] <= cache_wdata;
    end

    // Reference model: word memory plus per-line valid/tag
    logic [31:0] ref_mem [1024];
    bit          ref_valid [32];
    int          ref_tag [32];
    int          ref_hits, ref_misses;

    typedef struct {
        bit          is_wr;
        bit          hit;
        int unsigned req_cyc;
        logic [9:0]  addr;
        logic [31:0] data;
        int          hits_before;
        int          misses_after;
    } exp_t;
    exp_t sb[$];

    int n_checks = 0;
    int n_pass   = 0;

    function automatic void chk(string name, longint act, longint exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endfunction

    task automatic issue(input logic rd_i, input logic wr_i, input logic [9:0] a, input logic [31:0] d);
        exp_t e;
        int   idx;
        int   tag;
        idx = int'(a[6:2]);
        tag = int'(a[9:7]);
        e.is_wr       = wr_i;
        e.hit         = ref_valid[idx] && (ref_tag[idx] == tag);
        e.addr        = a;
        e.req_cyc     = cyc;
        e.hits_before = ref_hits;
        if (wr_i) begin
            ref_mem[a] = d;
            e.data = d;
        end else begin
            if (e.hit) begin
                ref_hits++;
            end else begin
                ref_valid[idx] = 1'b1;
                ref_tag[idx]   = tag;
                ref_misses++;
            end
            e.data = ref_mem[a];
        end
        e.misses_after = ref_misses;
        sb.push_back(e);
        cpu_rd    = rd_i;
        cpu_wr    = wr_i;
        cpu_addr  = a;
        cpu_wdata = d;
    endtask

    task automatic wait_ack();
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 30 && !seen; i++) begin
            @(negedge clk);
            seen = cpu_ack;
        end
        chk("ack_seen", seen, 1);
        if (!seen) sb.delete();
        @(posedge clk);
        #1;
        cpu_rd = 1'b0;
        cpu_wr = 1'b0;
    endtask

    task automatic check_outputs_zero(input string tag);
        chk({tag, "_ack"}, cpu_ack, 0);
        chk({tag, "_stall"}, cpu_stall, 0);
        chk({tag, "_cache_we"}, cache_we, 0);
        chk({tag, "_move_to_cache"}, move_to_cache, 0);
        chk({tag, "_write_in_mem"}, write_in_mem, 0);
        chk({tag, "_mem_addr"}, mem_word_address, 0);
`ifdef CACHE_STATS_EN
        chk({tag, "_hit_count"}, hit_count, 0);
        chk({tag, "_miss_count"}, miss_count, 0);
`endif
    endtask

    // Monitor: accumulates per-request traffic, compares on every ack
    initial begin
        int         mtc_n, we_n, wim_n, both_n, addr_bad, idx_bad;
        logic [7:0] we_seq;
        exp_t       e;
        int         lat;
        mtc_n = 0; we_n = 0; wim_n = 0; both_n = 0; addr_bad = 0; idx_bad = 0; we_seq = 8'd0;
        forever begin
            @(negedge clk);
            if (rst) begin
                mtc_n = 0; we_n = 0; wim_n = 0; both_n = 0; addr_bad = 0; idx_bad = 0; we_seq = 8'd0;
                continue;
            end
            if (move_to_cache && write_in_mem) both_n++;
            if (move_to_cache) begin
                mtc_n++;
                if (sb.size() == 0 || mem_word_address != {sb[0].addr[9:2], 2'b00}) addr_bad++;
            end
            if (write_in_mem) wim_n++;
            if (cache_we) begin
                we_n++;
                we_seq = {we_seq[5:0], cache_word};
                if (sb.size() == 0 || cache_index != sb[0].addr[6:2]) idx_bad++;
            end
            if (cpu_ack) begin
                if (sb.size() == 0) begin
                    chk("unexpected_ack", sb.size(), 1);
                end else begin
                    e   = sb.pop_front();
                    lat = int'(cyc - e.req_cyc);
                    chk("latency", lat, e.is_wr ? 1 : (e.hit ? 0 : 6));
                    chk("stall_at_ack", cpu_stall, e.is_wr);
                    chk("rd_wr_overlap", both_n, 0);
                    chk("refill_addr", addr_bad, 0);
                    chk("cache_index", idx_bad, 0);
                    if (e.is_wr) begin
                        chk("wr_mem_cycles", wim_n, 1);
                        chk("wr_mem_addr", mem_word_address, e.addr);
                        chk("wr_mem_data", mem_data_in, e.data);
                        chk("wr_cache_we", we_n, e.hit);
                        if (e.hit) chk("wr_cache_word", we_seq[1:0], e.addr[1:0]);
                        chk("wr_no_refill", mtc_n, 0);
                    end else begin
                        chk("rd_data", cache_arr[{e.addr[6:2], e.addr[1:0]}], e.data);
                        chk("rd_refill_cycles", mtc_n, e.hit ? 0 : 4);
                        chk("rd_cache_we", we_n, e.hit ? 0 : 4);
                        if (!e.hit) chk("rd_word_order", we_seq, 8'h1B);
                        chk("rd_no_mem_write", wim_n, 0);
                    end
`ifdef CACHE_STATS_EN
                    chk("hit_count", hit_count, e.hits_before);
                    chk("miss_count", miss_count, e.misses_after);
`endif
                end
                mtc_n = 0; we_n = 0; wim_n = 0; both_n = 0; addr_bad = 0; idx_bad = 0; we_seq = 8'd0;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [9:0]  a;
        logic [31:0] d;
        int          op;
        rst = 1'b1; cpu_rd = 1'b0; cpu_wr = 1'b0; cpu_addr = 10'd0; cpu_wdata = 32'd0;
        ref_hits = 0; ref_misses = 0;
        for (int i = 0; i < 1024; i++) begin
            d = $urandom;
            env_mem[i] = d;
            ref_mem[i] = d;
        end
        for (int i = 0; i < 128; i++) cache_arr[i] = 32'd0;
        for (int i = 0; i < 32; i++) begin
            ref_valid[i] = 1'b0;
            ref_tag[i]   = 0;
        end
        repeat (2) @(posedge clk);
        #1;
        check_outputs_zero("reset");
        rst = 1'b0;

        // Cold read, repeat read hit, write hit, write miss then read of that line
        issue(1'b1, 1'b0, 10'h024, 32'd0);          wait_ack();
        issue(1'b1, 1'b0, 10'h025, 32'd0);          wait_ack();
        issue(1'b0, 1'b1, 10'h026, 32'hDEADBEEF);   wait_ack();
        issue(1'b1, 1'b0, 10'h026, 32'd0);          wait_ack();
        issue(1'b0, 1'b1, 10'h3F0, 32'h1234_5678);  wait_ack();
        issue(1'b1, 1'b0, 10'h3F0, 32'd0);          wait_ack();
        issue(1'b1, 1'b1, 10'h3F1, 32'hCAFE_F00D);  wait_ack();

        // Reset during refill beat 2 abandons the line; held read restarts as a miss
        issue(1'b1, 1'b0, 10'h1A4, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        chk("pre_reset_refill", move_to_cache, 1);
        rst = 1'b1;
        #1;
        check_outputs_zero("mid_refill_reset");
        @(posedge clk);
        #1;
        sb.delete();
        for (int i = 0; i < 32; i++) ref_valid[i] = 1'b0;
        ref_hits = 0; ref_misses = 0;
        rst = 1'b0;
        issue(1'b1, 1'b0, 10'h1A4, 32'd0);          wait_ack();
        issue(1'b1, 1'b0, 10'h024, 32'd0);          wait_ack();
        issue(1'b1, 1'b0, 10'h1A7, 32'd0);          wait_ack();

        for (int n = 0; n < 300; n++) begin
            a  = {3'($urandom_range(0, 7)), 3'd0, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3))};
            d  = $urandom;
            op = $urandom_range(0, 9);
            if (op < 6)      issue(1'b1, 1'b0, a, d);
            else if (op < 9) issue(1'b0, 1'b1, a, d);
            else             issue(1'b1, 1'b1, a, d);
            wait_ack();
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #1;
            end
        end

        repeat (3) @(posedge clk);
        chk("scoreboard_drained", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/cache_controller.md
CACHE_CONTROLLER -- requirements
Module: cache_controller

Interface
REQ-001 SHALL have parameter INDEX_W, default 5, cache line index width; lines = 2**INDEX_W, tag width = 8-INDEX_W, 4 words/line.
REQ-002 SHALL have port clk  in  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  in  1  asynchronous, active-high reset.
REQ-004 SHALL have ports cpu_rd / cpu_wr  in  1 / 1  read / write request, held by CPU until cpu_ack.
REQ-005 SHALL have ports cpu_addr / cpu_wdata  in  10 / 32  word address / write data, stable while request held.
REQ-006 SHALL have ports cpu_ack / cpu_stall  out  1 / 1  request complete / controller busy or miss pending.
REQ-007 SHALL have ports cache_we, cache_index, cache_word, cache_wdata  out  1, INDEX_W, 2, 32  external cache data-array write port.
REQ-008 SHALL have ports mem_word_address, mem_data_in, write_in_mem, move_to_cache  out  10, 32, 1, 1  data memory command.
REQ-009 SHALL have port mem_data  in  32  data memory read data, registered one cycle after each move_to_cache cycle.
REQ-010 SHALL have ports hit_count / miss_count  out  16 / 16  statistics (CACHE_STATS_EN only).

Function
REQ-011 SHALL use FSM states IDLE, REFILL, LAST, WRITE; internal per-line valid bit and tag register array.
REQ-012 SHALL split cpu_addr: tag = [9:2+INDEX_W], index = [1+INDEX_W:2], word = [1:0]; hit = valid[index] and tag match, combinational.
REQ-013 SHALL, when cpu_rd and cpu_wr are both high in IDLE, treat the request as a write; read ignored until write acked.
REQ-014 SHALL, in IDLE with cpu_rd and hit, assert cpu_ack combinationally same cycle, cpu_stall low, no memory access.
REQ-015 SHALL, in IDLE with cpu_rd and miss, assert cpu_stall combinationally and enter REFILL with 2-bit counter cnt = 0.
REQ-016 SHALL, in REFILL, hold move_to_cache high continuously 4 cycles (cnt 0..3), mem_word_address = {tag,index,2'b00}, then go LAST.
REQ-017 SHALL assert cache_we when (REFILL and cnt >= 1) or LAST, cache_word = cnt-1 (3 in LAST), cache_wdata = mem_data, cache_index = request index.
REQ-018 SHALL, on LAST, set valid[index] = 1 and tag[index] = request tag, return to IDLE; held read then hits (6 cycles, request to ack).
REQ-019 SHALL, in IDLE with cpu_wr, assert cpu_stall and enter WRITE; write-through, no-write-allocate.
REQ-020 SHALL, in WRITE (one cycle), assert write_in_mem, mem_word_address = cpu_addr, mem_data_in = cpu_wdata, cpu_ack, and cache_we with cpu_wdata only if hit; then IDLE.
REQ-021 SHALL keep cpu_stall high in REFILL, LAST, WRITE; cpu_ack low in REFILL and LAST.
REQ-022 SHALL never assert write_in_mem and move_to_cache in the same cycle.
REQ-023 SHALL hold all command outputs low in IDLE except when REQ-014 applies (cpu_ack only).

Reset
REQ-024 SHALL on rst asynchronously: state IDLE, cnt 0, all valid bits 0, all outputs 0, counters 0.
REQ-025 SHALL, on rst mid-REFILL, abandon the line (valid stays 0); a held request restarts as a miss after release.

Configuration
REQ-026 SHALL, with CACHE_STATS_EN defined, increment hit_count on each read ack from IDLE hit not following refill, miss_count on each IDLE->REFILL, both saturating at 16'hFFFF.
REQ-027 SHALL, without CACHE_STATS_EN, omit the counter logic and the hit_count/miss_count ports entirely.

Verification
REQ-028 SHALL test cold read: cpu_rd addr 10'h024 after reset -> move_to_cache high exactly 4 cycles at mem_word_address 10'h024, cache_we words 0..3, cpu_ack 6 cycles after request.
REQ-029 SHALL test read hit: repeat read 10'h025 -> cpu_ack same cycle, no move_to_cache, hit_count = 1, miss_count = 1.
REQ-030 SHALL test write hit: cpu_wr 10'h026 data 32'hDEADBEEF -> one cycle write_in_mem plus cache_we word 2, cpu_ack in that cycle.
REQ-031 SHALL test write miss: cpu_wr 10'h3F0 -> write_in_mem one cycle, cache_we low, valid for index unchanged.
REQ-032 SHALL test rst pulse at refill cnt 2 -> all outputs 0 immediately, line invalid, subsequent read of same address refills again.
